// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch buffer.
package fetch_pkg;

    localparam int unsigned FETCH_DEPTH   = 4;
    localparam int unsigned FETCH_ADDR_W  = 8;
    localparam int unsigned FETCH_INSTR_W = 9;

    typedef struct packed {
        logic [31:0]              pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with push/pop, clear and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  fetch_entry_t                 i_wdata,
    output fetch_entry_t                 o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == CNT_W'(DEPTH));
        // A push into a full FIFO is only legal when the head leaves the same cycle.
        w_push  = i_push & (~w_full | i_pop);
        w_pop   = i_pop & ~w_empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues imem reads from the PC stream and queues {pc, instr} for decode.
// Optional FETCH_BYPASS_EN presents returning read data directly when the queue is empty.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = FETCH_DEPTH,
    parameter int unsigned ADDR_W  = FETCH_ADDR_W,
    parameter int unsigned INSTR_W = FETCH_INSTR_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  pc_in,
    input  logic                         pc_valid,
    output logic                         fetch_stall,
    input  logic                         flush,
    output logic                         imem_rd_en,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]           imem_rdata,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [INSTR_W-1:0]           dec_instr,
    output logic [31:0]                  dec_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic         r_inflight;
    logic [31:0]  r_inflight_pc;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_pending;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;
    logic             w_stall;
    logic             w_rd_issue;
    logic             w_return;
    logic             w_head_valid;
    logic             w_bypass;
    logic             w_fifo_push;
    logic             w_fifo_pop;

    // Stall counts the outstanding read as occupied and gives no credit for a same-cycle pop.
    always_comb begin
        w_pending  = {1'b0, w_count} + (CNT_W+1)'(r_inflight);
        w_stall    = (w_pending >= (CNT_W+1)'(DEPTH));
        w_rd_issue = pc_valid & ~w_stall & ~flush & ~reset;
        w_return   = r_inflight & ~flush;
    end

    always_comb begin
        w_head_valid = (w_count != '0);
`ifdef FETCH_BYPASS_EN
        w_bypass     = w_return & ~w_head_valid;
`else
        w_bypass     = 1'b0;
`endif
        w_fifo_pop   = w_head_valid & dec_ready;
        w_fifo_push  = w_return & ~(w_bypass & dec_ready);
        w_push_data  = '{pc: r_inflight_pc, instr: imem_rdata};
    end

    always_comb begin
        dec_valid = w_head_valid | w_bypass;
        dec_instr = '0;
        dec_pc    = '0;
        if (w_bypass) begin
            dec_instr = imem_rdata;
            dec_pc    = r_inflight_pc;
        end else if (w_head_valid) begin
            dec_instr = w_head.instr;
            dec_pc    = w_head.pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_rd_issue;
            if (w_rd_issue) begin
                r_inflight_pc <= pc_in;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_wdata (w_push_data),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign fetch_stall = w_stall;
    assign imem_rd_en  = w_rd_issue;
    assign imem_addr   = pc_in[ADDR_W-1:0];
    assign occupancy   = w_count;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with an in-order {pc, instr} scoreboard.
module tb_instr_fetch_buffer;

    typedef struct packed {
        logic [31:0] pc;
        logic [8:0]  instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        fetch_stall;
    logic        flush;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [8:0]  imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [8:0]  dec_instr;
    logic [31:0] dec_pc;
    logic [2:0]  occupancy;

    exp_t        sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int          handoffs = 0;
    logic        issued;
    logic        seen_first;
    logic [31:0] first_pc;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    always #5 clk = ~clk;

    // Instruction memory: returns 0x100 + address one cycle after the strobe.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= 9'h100 + {1'b0, imem_addr};
    end

    instr_fetch_buffer #(
        .DEPTH   (4),
        .ADDR_W  (8),
        .INSTR_W (9)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .fetch_stall (fetch_stall),
        .flush       (flush),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .occupancy   (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle: retire handoffs against the scoreboard, then apply flush/reset and new issues.
    task automatic monitor();
        exp_t e;
        issued = 1'b0;
        if (dec_valid && dec_ready) begin
            handoffs++;
            if (!seen_first) begin
                seen_first = 1'b1;
                first_pc   = dec_pc;
            end
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("handoff_pc", 64'(dec_pc), 64'(e.pc));
                chk("handoff_instr", 64'(dec_instr), 64'(e.instr));
            end
        end
        if (flush) chk("no_read_in_flush", 64'(imem_rd_en), 64'd0);
        if (reset || flush) begin
            sb.delete();
        end else if (imem_rd_en) begin
            chk("imem_addr", 64'(imem_addr), 64'(pc_in[7:0]));
            sb.push_back('{pc: pc_in, instr: 9'h100 + {1'b0, pc_in[7:0]}});
            issued = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic fl, input logic rdy);
        pc_valid  = pv;
        pc_in     = pc;
        flush     = fl;
        dec_ready = rdy;
        #1;
    endtask

    task automatic drain(input string tag);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 12 && (sb.size() != 0 || occupancy != 0); k++) step();
        chk(tag, 64'(sb.size()) + 64'(occupancy), 64'd0);
    endtask

    initial begin
        int          h0;
        int          n_acc;
        logic [31:0] pc;

        // Reset state: everything quiet except imem_addr following pc_in.
        reset      = 1'b1;
        seen_first = 1'b0;
        first_pc   = '0;
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        chk("rst_rd_en", 64'(imem_rd_en), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'h55);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_stall", 64'(fetch_stall), 64'd0);
        chk("rst_dec_pc", 64'(dec_pc), 64'd0);
        step();
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step();

        // Streaming with decode always ready.
        h0 = handoffs;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b1);
            step();
            if (i + 1 >= LAT) begin
                chk("stream_valid", 64'(dec_valid), 64'd1);
                chk("stream_pc", 64'(dec_pc), 64'(i + 1 - LAT));
                chk("stream_instr", 64'(dec_instr), 64'(9'h100 + 9'(i + 1 - LAT)));
            end else begin
                chk("stream_latency", 64'(dec_valid), 64'd0);
            end
            chk("stream_no_stall", 64'(fetch_stall), 64'd0);
        end
        drain("stream_drain");
        chk("stream_count", 64'(handoffs - h0), 64'd8);

        // Back-pressure: four fetches fill the queue, then the PC is held.
        h0    = handoffs;
        n_acc = 0;
        pc    = 32'h10;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, pc, 1'b0, 1'b0);
            step();
            if (issued) begin
                n_acc++;
                pc++;
            end
        end
        drive(1'b1, pc, 1'b0, 1'b0);
        chk("bp_accepted", 64'(n_acc), 64'd4);
        chk("bp_stall", 64'(fetch_stall), 64'd1);
        chk("bp_occ", 64'(occupancy), 64'd4);
        chk("bp_rd_blocked", 64'(imem_rd_en), 64'd0);
        chk("bp_head_pc", 64'(dec_pc), 64'h10);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        chk("bp_unstall", 64'(fetch_stall), 64'd0);
        for (int i = 0; i < 3; i++) step();
        chk("bp_empty", 64'(occupancy), 64'd0);
        chk("bp_drained", 64'(handoffs - h0), 64'd4);

        // Simultaneous push and pop at DEPTH-1.
        h0 = handoffs;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        chk("pp_occ3", 64'(occupancy), 64'd3);
        drive(1'b1, 32'h33, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("pp_stall_no_credit", 64'(fetch_stall), 64'd1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pp_occ_hold", 64'(occupancy), 64'd3);
        chk("pp_head", 64'(dec_pc), 64'h31);
        drain("pp_drain");
        chk("pp_count", 64'(handoffs - h0), 64'd4);

        // Flush with two queued and one in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0);
            step();
        end
        chk("fl_occ2", 64'(occupancy), 64'd2);
        drive(1'b1, 32'h99, 1'b1, 1'b1);
        chk("fl_rd_en", 64'(imem_rd_en), 64'd0);
        chk("fl_head_valid", 64'(dec_valid), 64'd1);
        chk("fl_head_pc", 64'(dec_pc), 64'h40);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("fl_occ0", 64'(occupancy), 64'd0);
        chk("fl_dec_valid", 64'(dec_valid), 64'd0);
        seen_first = 1'b0;
        drive(1'b1, 32'h20, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 6 && !seen_first; k++) step();
        chk("fl_seen", 64'(seen_first), 64'd1);
        chk("fl_first_pc", 64'(first_pc), 64'h20);
        drain("fl_drain");

        // Reset mid-stream with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        chk("rs_occ3", 64'(occupancy), 64'd3);
        reset = 1'b1;
        drive(1'b1, 32'h57, 1'b0, 1'b0);
        chk("rs_async_occ", 64'(occupancy), 64'd0);
        step();
        chk("rs_occ", 64'(occupancy), 64'd0);
        chk("rs_dec_valid", 64'(dec_valid), 64'd0);
        chk("rs_rd_en", 64'(imem_rd_en), 64'd0);
        reset = 1'b0;
        h0 = handoffs;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        chk("rs_after_occ", 64'(occupancy), 64'd0);
        chk("rs_after_valid", 64'(dec_valid), 64'd0);
        chk("rs_no_handoff", 64'(handoffs - h0), 64'd0);

        // Single fetch into an empty queue, ready then not ready.
        drive(1'b1, 32'h60, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
`ifdef FETCH_BYPASS_EN
        chk("bp1_valid", 64'(dec_valid), 64'd1);
        chk("bp1_pc", 64'(dec_pc), 64'h60);
        chk("bp1_instr", 64'(dec_instr), 64'h160);
        step();
        chk("bp1_occ", 64'(occupancy), 64'd0);
`else
        chk("nb1_valid", 64'(dec_valid), 64'd0);
        step();
        chk("nb1_occ", 64'(occupancy), 64'd1);
        chk("nb1_pc", 64'(dec_pc), 64'h60);
`endif
        drain("one_drain");
        drive(1'b1, 32'h61, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_BYPASS_EN
        chk("bp2_valid", 64'(dec_valid), 64'd1);
        chk("bp2_pc", 64'(dec_pc), 64'h61);
`else
        chk("nb2_valid", 64'(dec_valid), 64'd0);
`endif
        step();
        chk("q_occ1", 64'(occupancy), 64'd1);
        chk("q_pc", 64'(dec_pc), 64'h61);
        chk("q_instr", 64'(dec_instr), 64'h161);
        drain("q_drain");

        chk("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
